// File: rtl/tcb_lib_router.sv
// tcb_lib_router: TCB address decoder plus demultiplexer.
// One upstream manager fans out to SPN downstream ports by base/mask match,
// lowest index first. Unmapped requests are accepted locally, answered with
// an error response, and logged in sticky error-capture registers.

// Per-port address comparator: only bits set in msk take part in the compare.
module tcb_lib_router_match #(
   parameter int unsigned AW = 32
)(
   input  logic [AW-1:0] adr,
   input  logic [AW-1:0] base,
   input  logic [AW-1:0] msk,
   output logic          match
);

   assign match = ~|((adr ^ base) & msk);

endmodule

module tcb_lib_router #(
   parameter int unsigned                 PHY_ADR = 32,
   parameter int unsigned                 PHY_DAT = 32,
   parameter int unsigned                 PHY_DLY = 1,
   parameter int unsigned                 SPN     = 2,
   parameter logic [SPN-1:0][PHY_ADR-1:0] ADR     = '0,
   parameter logic [SPN-1:0][PHY_ADR-1:0] MSK     = '0,
   parameter logic [31:0]                 ERR_RDT = 32'hDEADBEEF,
   parameter int unsigned                 CNT_W   = 8
)(
   input  logic                            clk,
   input  logic                            rst,
   // upstream port, the manager connects here
   input  logic                            sub_vld,
   output logic                            sub_rdy,
   input  logic                            sub_req_wen,
   input  logic [PHY_ADR-1:0]              sub_req_adr,
   input  logic [PHY_DAT/8-1:0]            sub_req_ben,
   input  logic [PHY_DAT-1:0]              sub_req_wdt,
   output logic [PHY_DAT-1:0]              sub_rsp_rdt,
   output logic                            sub_rsp_sts_err,
   // downstream ports
   output logic [SPN-1:0]                  man_vld,
   input  logic [SPN-1:0]                  man_rdy,
   output logic [SPN-1:0]                  man_req_wen,
   output logic [SPN-1:0][PHY_ADR-1:0]     man_req_adr,
   output logic [SPN-1:0][PHY_DAT/8-1:0]   man_req_ben,
   output logic [SPN-1:0][PHY_DAT-1:0]     man_req_wdt,
   input  logic [SPN-1:0][PHY_DAT-1:0]     man_rsp_rdt,
   input  logic [SPN-1:0]                  man_rsp_sts_err,
   // error capture
   input  logic                            err_clr,
   output logic                            err_vld,
   output logic [PHY_ADR-1:0]              err_adr,
   output logic [CNT_W-1:0]                err_cnt
);

   // index SPN is the internal error target
   localparam int unsigned        SPL     = $clog2(SPN+1);
   localparam logic [SPL-1:0]     SEL_ERR = SPL'(SPN);
   localparam logic [PHY_DAT-1:0] ERR_DAT = PHY_DAT'(ERR_RDT);

   logic [SPN-1:0]            match;
   logic [SPL-1:0]            sel;
   logic                      unm;
   logic                      trn;
   logic [PHY_DLY:0]          vld_pipe;
   logic [PHY_DLY:0][SPL-1:0] sel_pipe;
   logic                      rsp_vld;
   logic [SPL-1:0]            rsp_idx;

   // per-port lanes: address compare and request broadcast
   generate
      for (genvar i = 0; i < SPN; i++) begin : g_lane
         tcb_lib_router_match #(.AW(PHY_ADR)) u_match (
            .adr   (sub_req_adr),
            .base  (ADR[i]),
            .msk   (MSK[i]),
            .match (match[i])
         );
         assign man_req_wen[i] = sub_req_wen;
         assign man_req_adr[i] = sub_req_adr;
         assign man_req_ben[i] = sub_req_ben;
         assign man_req_wdt[i] = sub_req_wdt;
      end
   endgenerate

   // lowest-index match wins; no match selects the local error target
   always_comb begin
      sel = SEL_ERR;
      for (int i = int'(SPN) - 1; i >= 0; i--) begin
         if (match[i]) sel = SPL'(i);
      end
   end

   assign unm = (sel == SEL_ERR);

   // forward vld to the selected port only; unmapped requests are always ready
   always_comb begin
      man_vld = '0;
      sub_rdy = 1'b1;
      for (int i = 0; i < SPN; i++) begin
         if (sel == SPL'(i)) begin
            man_vld[i] = sub_vld;
            sub_rdy    = man_rdy[i];
         end
      end
   end

   assign trn = sub_vld & sub_rdy;

   // select pipeline: entry 0 is the live transfer, entry k is k cycles old;
   // it never stalls, so response latency is fixed for every target
   generate
      if (PHY_DLY > 0) begin : g_pipe
         logic [PHY_DLY-1:0]          vld_q;
         logic [PHY_DLY-1:0][SPL-1:0] sel_q;

         // shift by one stage each cycle; reset flushes in-flight responses
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vld_q <= '0;
               sel_q <= '0;
            end else begin
               vld_q <= vld_pipe[PHY_DLY-1:0];
               sel_q <= sel_pipe[PHY_DLY-1:0];
            end
         end

         assign vld_pipe = {vld_q, trn};
         assign sel_pipe = {sel_q, sel};
      end else begin : g_nopipe
         assign vld_pipe = trn;
         assign sel_pipe = sel;
      end
   endgenerate

   assign rsp_vld = vld_pipe[PHY_DLY];
   assign rsp_idx = sel_pipe[PHY_DLY];

   // response steering: selected port, local error, or idle zero
   always_comb begin
      sub_rsp_rdt     = '0;
      sub_rsp_sts_err = 1'b0;
      if (rsp_vld) begin
         if (rsp_idx == SEL_ERR) begin
            sub_rsp_rdt     = ERR_DAT;
            sub_rsp_sts_err = 1'b1;
         end
         for (int i = 0; i < SPN; i++) begin
            if (rsp_idx == SPL'(i)) begin
               sub_rsp_rdt     = man_rsp_rdt[i];
               sub_rsp_sts_err = man_rsp_sts_err[i];
            end
         end
      end
   end

   // sticky error capture: first address wins, count saturates,
   // a new error in the clear cycle survives the clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_vld <= 1'b0;
         err_adr <= '0;
         err_cnt <= '0;
      end else if (trn && unm) begin
         if (err_clr || !err_vld) begin
            err_vld <= 1'b1;
            err_adr <= sub_req_adr;
         end
         if (err_clr)
            err_cnt <= CNT_W'(1);
         else if (err_cnt != '1)
            err_cnt <= err_cnt + CNT_W'(1);
      end else if (err_clr) begin
         err_vld <= 1'b0;
         err_adr <= '0;
         err_cnt <= '0;
      end
   end

endmodule
